inst_encoder: RTL
=================

Name: inst_encoder

Overview:
- Streaming ARM instruction encoder; the inverse of the ID-stage decode path.
- Accepts decoded instruction fields (mode, opcode, S/L bit, condition, registers, operands) over a valid/ready handshake.
- Packs each accepted field set into a 32-bit instruction word, tags it with an instruction-memory byte address, and buffers it in a small FIFO.
- Used by the program loader and the self-test bench to write instruction memory.

Parameters:
- ADDR_W, 32, width of out_addr and base_addr.
- ADDR_STEP, 4, address increment per accepted instruction.
- DEPTH, 2, output FIFO entries (power of two, >= 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- load_base  in  1  pulse; next assigned address := base_addr.
- base_addr  in  ADDR_W  new base address.
- in_valid  in  1  field set present.
- in_ready  out  1  encoder can accept.
- cond  in  4  condition field.
- mode  in  2  00 arith, 01 memory, 10 branch, 11 illegal.
- opcode  in  4  arithmetic opcode (ignored for mode 01/10).
- s_bit  in  1  S for arith; L for memory (1 LDR, 0 STR).
- imm_bit  in  1  I bit for arith.
- rn  in  4  first source register.
- rd  in  4  destination register.
- shift_operand  in  12  shifter operand / memory offset.
- signed_imm_24  in  24  branch offset.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_inst  out  32  encoded word at head.
- out_addr  out  ADDR_W  address of head.
- err_count  out  8  illegal inputs seen, saturating.

Behaviour:
- Reset (async, immediate): FIFO empty, out_valid=0, out_inst=0, out_addr=0, address counter=0, err_count=0; in_ready=1 on the first cycle after reset deassertion.
- Accept on in_valid&&in_ready at a rising edge. in_ready = !full; it is combinationally independent of out_ready (no pass-through when full).
- Output pop on out_valid&&out_ready. A push and a pop in the same cycle are both legal; occupancy is then unchanged.
- Latency: an entry accepted into an empty FIFO at edge N is visible with out_valid=1 after edge N. Order is strict FIFO.
- Head stability: out_inst/out_addr are stable while out_valid&&!out_ready.
- Address assignment:
  - Each accepted entry takes the current counter value; the counter then += ADDR_STEP, wrapping mod 2^ADDR_W.
  - When load_base is asserted: the counter becomes base_addr + ADDR_STEP if an accept occurs the same cycle, with the accepted entry taking base_addr; otherwise the counter becomes base_addr.
- Encoding, common fields: [31:28]=cond, [27:26]=mode.
- Encoding, arith (mode 00): [25]=imm_bit, [24:21]=opcode, [20]=s_bit, [19:16]=rn, [15:12]=rd, [11:0]=shift_operand.
  - CMP (1010) and TST (1000): [20] forced 1, [15:12] forced 0.
  - MOV (1101) and MVN (1111): [19:16] forced 0.
- Encoding, memory (mode 01): [25]=0, [24:21]=0100, [20]=s_bit, [19:16]=rn, [15:12]=rd, [11:0]=shift_operand.
- Encoding, branch (mode 10): [25]=1, [24]=0, [23:0]=signed_imm_24.
- Illegal inputs (mode 11, or an arith opcode outside {1101,1111,0100,0101,0010,0110,0000,1100,0001,1010,1000}):
  - entry still pushed with word 32'h00000000 (NOP); address still consumed;
  - err_count increments, saturating at 255.
- Reset mid-stream discards all FIFO contents; no partial state survives.

Optional Feature:
- Macro: INST_ENC_CHECK_EN.
- Defined: illegal-input detection, NOP substitution and err_count are active as described above.
- Undefined:
  - no legality check; mode 11 and unknown opcodes are packed using the arith layout with the raw mode/opcode;
  - err_count tied to 0;
  - CMP/TST/MOV/MVN field forcing remains active.

Test Plan:
- Reset, then ADD: cond=1110, mode=00, imm_bit=1, opcode=0100, s=0, rn=2, rd=1, shift=0x005 -> out_inst=0xE2821005, out_addr=0, out_valid one edge after accept.
- CMP: opcode=1010, s=0, imm_bit=0, rn=3, rd=7, shift=0x004 -> 0xE1530004 (S forced 1, Rd forced 0); out_addr=4.
- load_base=1 with base_addr=0x100 in the same cycle as LDR rn=1, rd=0, off=8, s=1; then STR with the same fields, s=0 -> 0xE4910008 at 0x100, then 0xE4810008 at 0x104.
- Branch cond=1110, imm=0xFFFFFE -> 0xEAFFFFFE. Hold out_ready=0 for 3 pushes: in_ready falls after 2 entries, the head stays stable, and order is preserved on release.
- mode=11 -> 0x00000000 and err_count=1. Repeat 300 times -> err_count saturates at 255. With the macro undefined -> err_count stays 0.
- Assert rst mid-stream with 2 entries queued -> out_valid=0 immediately; next accept gets out_addr=0.

Source files
------------

// File: rtl/inst_encoder.sv
// inst_encoder: streaming ARM instruction encoder.
// Decoded instruction fields arrive over a valid/ready handshake, get packed
// into a 32-bit instruction word, are tagged with an instruction-memory byte
// address and are queued in a small output FIFO.
//
// Optional feature macro: INST_ENC_CHECK_EN
//   defined   - illegal mode/opcode detection, NOP substitution, err_count
//   undefined - fields packed raw using the arith layout, err_count tied to 0
module inst_encoder #(
  parameter int ADDR_W    = 32,
  parameter int ADDR_STEP = 4,
  parameter int DEPTH     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_base,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        cond,
  input  logic [1:0]        mode,
  input  logic [3:0]        opcode,
  input  logic              s_bit,
  input  logic              imm_bit,
  input  logic [3:0]        rn,
  input  logic [3:0]        rd,
  input  logic [11:0]       shift_operand,
  input  logic [23:0]       signed_imm_24,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic [7:0]        err_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] MODE_ARITH  = 2'b00;
  localparam logic [1:0] MODE_MEMORY = 2'b01;
  localparam logic [1:0] MODE_BRANCH = 2'b10;

  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  // FIFO storage and bookkeeping
  logic [31:0]       inst_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;
  logic              full;
  logic              push;
  logic              pop;

  // Address generation
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] entry_addr;

  // Encoder datapath
  logic              s_eff;
  logic [3:0]        rn_eff;
  logic [3:0]        rd_eff;
  logic [31:0]       arith_word;
  logic [31:0]       enc_word;
  logic [31:0]       push_word;

  assign full      = (count == (PW+1)'(DEPTH));
  assign in_ready  = !full;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Empty FIFO presents zeros so the reset-time outputs are clean
  assign out_inst  = out_valid ? inst_mem[rd_ptr] : 32'h0;
  assign out_addr  = out_valid ? addr_mem[rd_ptr] : '0;

  // A load_base in the accept cycle redirects the accepted entry itself
  assign entry_addr = load_base ? base_addr : addr_cnt;

  // Pack the field set; CMP/TST/MOV/MVN implicit fields are forced here
  always_comb begin
    s_eff  = s_bit;
    rn_eff = rn;
    rd_eff = rd;
    if (opcode == OP_CMP || opcode == OP_TST) begin
      s_eff  = 1'b1;
      rd_eff = 4'h0;
    end
    if (opcode == OP_MOV || opcode == OP_MVN) begin
      rn_eff = 4'h0;
    end
    arith_word = {cond, mode, imm_bit, opcode, s_eff, rn_eff, rd_eff, shift_operand};
    case (mode)
      MODE_MEMORY: enc_word = {cond, MODE_MEMORY, 1'b0, 4'b0100, s_bit, rn, rd, shift_operand};
      MODE_BRANCH: enc_word = {cond, MODE_BRANCH, 1'b1, 1'b0, signed_imm_24};
      default:     enc_word = arith_word;
    endcase
  end

`ifdef INST_ENC_CHECK_EN
  logic legal_op;
  logic illegal;

  // Opcodes the downstream decoder understands for the arith layout
  always_comb begin
    case (opcode)
      4'b1101, 4'b1111, 4'b0100, 4'b0101, 4'b0010, 4'b0110,
      4'b0000, 4'b1100, 4'b0001, 4'b1010, 4'b1000: legal_op = 1'b1;
      default:                                     legal_op = 1'b0;
    endcase
  end

  assign illegal   = (mode == 2'b11) || ((mode == MODE_ARITH) && !legal_op);
  assign push_word = illegal ? 32'h0000_0000 : enc_word;

  // Count illegal field sets that were actually accepted, saturating at 255
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= 8'h00;
    end else if (push && illegal && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'h01;
    end
  end
`else
  assign push_word = enc_word;
  assign err_count = 8'h00;
`endif

  // Address counter: advances past each accepted entry, reloads on load_base
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_cnt <= '0;
    end else if (push) begin
      addr_cnt <= entry_addr + ADDR_W'(ADDR_STEP);
    end else if (load_base) begin
      addr_cnt <= base_addr;
    end
  end

  // FIFO storage writes; entries are cleared on reset so nothing survives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= 32'h0;
        addr_mem[i] <= '0;
      end
    end else if (push) begin
      inst_mem[wr_ptr] <= push_word;
      addr_mem[wr_ptr] <= entry_addr;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keeps the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
